// File: rtl/clarvi_split_sequencer.sv
// Runs 64-bit ops on the 32-bit clarvi_ALU as two halves and merges them into one writeback beat.
// Optional macro CLARVI_SEQ_FASTPATH_EN: present the beat during SECOND for 2-cycle latency.
package clarvi_seq_pkg;

  typedef enum logic [3:0] {
    ADD, SUB, SLT, SLTU, XOR, OR, AND, SL, SRL, SRA
  } alu_op_t;

  typedef struct packed {
    alu_op_t     op;
    logic        is32_bit_op;
    logic        instr_part;
    logic [31:0] immediate;
  } instr_t;

endpackage

module clarvi_split_sequencer
  import clarvi_seq_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  instr_t      in_instr,
  input  logic [4:0]  in_rd,
  input  logic [63:0] in_rs1,
  input  logic [63:0] in_rs2,
  output instr_t      alu_instr,
  output logic [31:0] alu_rs1,
  output logic [31:0] alu_rs2,
  output logic        alu_stall,
  input  logic [31:0] alu_result,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_value
);

  typedef enum logic [1:0] {IDLE, FIRST, SECOND, OUT} state_t;

  state_t      state_q, state_d;
  instr_t      instr_q, instr_d;
  logic [4:0]  rd_q, rd_d;
  logic [63:0] rs1_q, rs1_d;
  logic [63:0] rs2_q, rs2_d;
  logic [63:0] wb_value_q, wb_value_d;
  logic        hi_first_q, hi_first_d;

  logic        issuing;
  logic        part;
  logic        accept;
  logic [63:0] merged;

  always_comb begin
    issuing   = (state_q == FIRST) || (state_q == SECOND);
    part      = (state_q == SECOND) ? !hi_first_q : hi_first_q;
    merged    = part ? {alu_result, wb_value_q[31:0]} : {wb_value_q[63:32], alu_result};

    alu_instr            = instr_q;
    alu_instr.instr_part = part;
    alu_rs1   = part ? rs1_q[63:32] : rs1_q[31:0];
    alu_rs2   = part ? rs2_q[63:32] : rs2_q[31:0];
    alu_stall = !issuing;
    wb_rd     = rd_q;

`ifdef CLARVI_SEQ_FASTPATH_EN
    wb_valid = (state_q == OUT) || (state_q == SECOND);
    wb_value = (state_q == SECOND) ? merged : wb_value_q;
    in_ready = ((state_q == IDLE) ||
                (((state_q == OUT) || (state_q == SECOND)) && wb_ready)) && !flush && reset;
`else
    wb_valid = (state_q == OUT);
    wb_value = wb_value_q;
    in_ready = ((state_q == IDLE) || ((state_q == OUT) && wb_ready)) && !flush && reset;
`endif

    accept = in_valid && in_ready;
  end

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    rd_d       = rd_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    hi_first_d = hi_first_q;
    wb_value_d = wb_value_q;

    case (state_q)
      IDLE:   if (accept) state_d = FIRST;
      FIRST:  state_d = SECOND;
`ifdef CLARVI_SEQ_FASTPATH_EN
      SECOND: begin
        if (wb_ready) state_d = accept ? FIRST : IDLE;
        else          state_d = OUT;
      end
`else
      SECOND: state_d = OUT;
`endif
      OUT:    if (wb_ready) state_d = accept ? FIRST : IDLE;
      default: state_d = IDLE;
    endcase

    if (issuing) wb_value_d = merged;

    // Compares and right shifts need the upper word first so the ALU can carry
    // sign/equality or shifted-in bits down into the lower word.
    if (accept) begin
      instr_d    = in_instr;
      rd_d       = in_rd;
      rs1_d      = in_rs1;
      rs2_d      = in_rs2;
      hi_first_d = !in_instr.is32_bit_op &&
                   ((in_instr.op == SLT) || (in_instr.op == SLTU) ||
                    (in_instr.op == SRL) || (in_instr.op == SRA));
    end

    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      instr_q    <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      hi_first_q <= 1'b0;
      wb_value_q <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      hi_first_q <= hi_first_d;
      wb_value_q <= wb_value_d;
    end
  end

endmodule

// File: tb/tb_clarvi_split_sequencer.sv
// Directed bench for clarvi_split_sequencer: plays the ALU with hand-computed half results.
`timescale 1ns/1ps
module tb_clarvi_split_sequencer;
  import clarvi_seq_pkg::*;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  instr_t      in_instr;
  logic [4:0]  in_rd;
  logic [63:0] in_rs1;
  logic [63:0] in_rs2;
  instr_t      alu_instr;
  logic [31:0] alu_rs1;
  logic [31:0] alu_rs2;
  logic        alu_stall;
  logic [31:0] alu_result;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [63:0] wb_value;

  int check_count = 0;
  int error_count = 0;

  clarvi_split_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .alu_instr  (alu_instr),
    .alu_rs1    (alu_rs1),
    .alu_rs2    (alu_rs2),
    .alu_stall  (alu_stall),
    .alu_result (alu_result),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_rd      (wb_rd),
    .wb_value   (wb_value)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // instr_part is deliberately set to 1 so a sequencer that passes it through gets caught.
  function automatic instr_t mk_instr(input alu_op_t op, input logic is32);
    instr_t i;
    i = '0;
    i.op          = op;
    i.is32_bit_op = is32;
    i.instr_part  = 1'b1;
    i.immediate   = 32'h0;
    return i;
  endfunction

  task automatic applyStimulus(input alu_op_t op, input logic is32,
                               input logic [63:0] rs1, input logic [63:0] rs2,
                               input logic [4:0] rd, input logic hi_first,
                               input logic [31:0] res_first, input logic [31:0] res_second,
                               input logic [63:0] exp_wb, input int hold);
    @(negedge clock);
    in_valid = 1'b1;
    in_instr = mk_instr(op, is32);
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    wb_ready = (hold == 0);
    #1 checkOutput("in_ready_offer", in_ready, 1);

    @(negedge clock);
    in_valid   = 1'b0;
    alu_result = res_first;
    #1;
    checkOutput("stall_first", alu_stall, 0);
    checkOutput("part_first", alu_instr.instr_part, hi_first);
    checkOutput("rs1_first", alu_rs1, hi_first ? rs1[63:32] : rs1[31:0]);
    checkOutput("rs2_first", alu_rs2, hi_first ? rs2[63:32] : rs2[31:0]);
    checkOutput("wb_valid_first", wb_valid, 0);

    @(negedge clock);
    alu_result = res_second;
    #1;
    checkOutput("stall_second", alu_stall, 0);
    checkOutput("part_second", alu_instr.instr_part, !hi_first);
    checkOutput("rs1_second", alu_rs1, hi_first ? rs1[31:0] : rs1[63:32]);
    checkOutput("rs2_second", alu_rs2, hi_first ? rs2[31:0] : rs2[63:32]);
    checkOutput("wb_valid_second", wb_valid, 0);

    @(negedge clock);
    alu_result = 32'hDEAD_BEEF;
    #1;
    checkOutput("wb_valid_out", wb_valid, 1);
    checkOutput("wb_value_out", wb_value, exp_wb);
    checkOutput("wb_rd_out", wb_rd, rd);
    checkOutput("stall_out", alu_stall, 1);
    checkOutput("in_ready_out", in_ready, hold == 0);

    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      #1;
      checkOutput("wb_valid_hold", wb_valid, 1);
      checkOutput("wb_value_hold", wb_value, exp_wb);
      checkOutput("wb_rd_hold", wb_rd, rd);
      checkOutput("in_ready_hold", in_ready, 0);
      checkOutput("stall_hold", alu_stall, 1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset      = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_instr   = '0;
    in_rd      = '0;
    in_rs1     = '0;
    in_rs2     = '0;
    alu_result = '0;
    wb_ready   = 1'b1;

    #3;
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_wb_valid", wb_valid, 0);
    checkOutput("rst_stall", alu_stall, 1);
    checkOutput("rst_wb_value", wb_value, 0);
    checkOutput("rst_wb_rd", wb_rd, 0);
    @(negedge clock);
    reset = 1'b1;
    #1 checkOutput("post_rst_in_ready", in_ready, 1);

    applyStimulus(ADD, 1'b0, 64'h00000000_FFFFFFFF, 64'h1, 5'd3, 1'b0,
                  32'h00000000, 32'h00000001, 64'h00000001_00000000, 0);
    applyStimulus(SLT, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'h1, 5'd4, 1'b1,
                  32'h00000000, 32'h00000001, 64'h00000000_00000001, 0);
    applyStimulus(SRA, 1'b0, 64'h80000000_00000000, 64'h4, 5'd5, 1'b1,
                  32'hF8000000, 32'h00000000, 64'hF8000000_00000000, 0);
    applyStimulus(SL, 1'b1, 64'h00000000_40000000, 64'h1, 5'd6, 1'b0,
                  32'h80000000, 32'hFFFFFFFF, 64'hFFFFFFFF_80000000, 0);
    applyStimulus(SRL, 1'b1, 64'h12345678_9ABCDEF0, 64'h4, 5'd8, 1'b0,
                  32'h09ABCDEF, 32'h00000000, 64'h00000000_09ABCDEF, 0);
    applyStimulus(SLTU, 1'b0, 64'h1, 64'h2, 5'd9, 1'b1,
                  32'h00000000, 32'h00000001, 64'h00000000_00000001, 0);

    // Back-pressure for 5 cycles, then the next op is offered while still in OUT.
    applyStimulus(ADD, 1'b0, 64'h00000001_00000002, 64'h00000003_00000004, 5'd10, 1'b0,
                  32'h00000006, 32'h00000004, 64'h00000004_00000006, 5);
    applyStimulus(XOR, 1'b0, 64'hFFFF0000_0000FFFF, 64'h0F0F0F0F_F0F0F0F0, 5'd11, 1'b0,
                  32'hF0F00F0F, 32'hF0F00F0F, 64'hF0F00F0F_F0F00F0F, 0);

    // Flush during FIRST while a second instruction is offered.
    @(negedge clock);
    in_valid = 1'b1;
    in_instr = mk_instr(ADD, 1'b0);
    in_rd    = 5'd12;
    in_rs1   = 64'h1;
    in_rs2   = 64'h1;
    wb_ready = 1'b1;
    @(negedge clock);
    in_instr = mk_instr(SUB, 1'b0);
    in_rd    = 5'd13;
    flush    = 1'b1;
    #1;
    checkOutput("flush_in_ready", in_ready, 0);
    checkOutput("flush_stall_first", alu_stall, 0);
    @(negedge clock);
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("flush_idle_stall", alu_stall, 1);
    checkOutput("flush_wb_valid", wb_valid, 0);
    checkOutput("flush_in_ready_idle", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      checkOutput("flush_no_beat", wb_valid, 0);
      checkOutput("flush_no_issue", alu_stall, 1);
    end

    // Reset pulled low in the middle of SECOND.
    @(negedge clock);
    in_valid = 1'b1;
    in_instr = mk_instr(SRA, 1'b0);
    in_rd    = 5'd14;
    in_rs1   = 64'hAAAAAAAA_55555555;
    in_rs2   = 64'h8;
    @(negedge clock);
    in_valid   = 1'b0;
    alu_result = 32'h12345678;
    @(negedge clock);
    #1 checkOutput("mid_stall_second", alu_stall, 0);
    #1 reset = 1'b0;
    #1;
    checkOutput("async_rst_wb_valid", wb_valid, 0);
    checkOutput("async_rst_in_ready", in_ready, 0);
    checkOutput("async_rst_stall", alu_stall, 1);
    checkOutput("async_rst_wb_value", wb_value, 0);
    checkOutput("async_rst_wb_rd", wb_rd, 0);
    checkOutput("async_rst_alu_instr", alu_instr, 0);
    @(negedge clock);
    reset = 1'b1;
    #1 checkOutput("rerelease_in_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1 checkOutput("rst_no_beat", wb_valid, 0);
    end

    applyStimulus(SUB, 1'b0, 64'h5, 64'h3, 5'd15, 1'b0,
                  32'h00000002, 32'h00000000, 64'h00000000_00000002, 0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
